// File: rtl/program_sequencer.sv
// Program counter with increment/load/relative-branch/call/return and an internal return stack.
// Optional overflow/underflow guard: define PROGRAM_SEQUENCER_STACK_GUARD_EN.
module program_sequencer #(
    parameter int unsigned       WIDTH    = 16,
    parameter int unsigned       OFF_W    = 8,
    parameter int unsigned       DEPTH    = 8,
    parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       r,
    input  logic [WIDTH-1:0]           a,
    input  logic [OFF_W-1:0]           off,
    input  logic                       we,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       br,
    input  logic                       e,
    input  logic                       oe,
    output logic [WIDTH-1:0]           o,
    output logic [WIDTH-1:0]           pc_q,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf,
    output logic                       unf
);

    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

`ifdef PROGRAM_SEQUENCER_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] stack [DEPTH];
    logic [PW-1:0]    sp;       // next free slot; wraps modulo DEPTH
    logic [PW-1:0]    sp_inc;
    logic [PW-1:0]    sp_dec;
    logic [DW-1:0]    cnt;
    logic [WIDTH-1:0] boff;
    logic             ovf_q;
    logic             unf_q;

    always_comb begin
        sp_inc = (sp == PW'(DEPTH - 1)) ? '0 : sp + PW'(1);
        sp_dec = (sp == '0) ? PW'(DEPTH - 1) : sp - PW'(1);
        boff   = WIDTH'($signed(off));
    end

    assign full  = (cnt == DW'(DEPTH));
    assign empty = (cnt == '0);

    always_ff @(posedge clk) begin
        if (r) begin
            pc    <= RESET_PC;
            sp    <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (we) begin
            pc <= a;
        end else if (call) begin
            if (GUARD && full) begin
                ovf_q <= 1'b1;
            end else begin
                // Unguarded push when full overwrites the oldest slot; count saturates.
                stack[sp] <= pc + WIDTH'(1);
                sp        <= sp_inc;
                pc        <= a;
                if (!full)
                    cnt <= cnt + DW'(1);
            end
        end else if (ret) begin
            if (GUARD && empty) begin
                unf_q <= 1'b1;
            end else begin
                pc <= stack[sp_dec];
                sp <= sp_dec;
                if (!empty)
                    cnt <= cnt - DW'(1);
            end
        end else if (br) begin
            pc <= pc + boff;
        end else if (e) begin
            pc <= pc + WIDTH'(1);
        end
    end

    assign pc_q  = pc;
    assign o     = oe ? pc : 'z;
    assign depth = cnt;
    assign ovf   = GUARD ? ovf_q : 1'b0;
    assign unf   = GUARD ? unf_q : 1'b0;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer (default parameters); follows the guard macro if defined.
module tb_program_sequencer;

    logic        clk = 1'b0;
    logic        r, we, call, ret, br, e, oe;
    logic [15:0] a;
    logic [7:0]  off;
    logic [15:0] o;
    logic [15:0] pc_q;
    logic [3:0]  depth;
    logic        full, empty, ovf, unf;

    int unsigned errors = 0;
    int unsigned checks = 0;

    program_sequencer #(
        .WIDTH(16), .OFF_W(8), .DEPTH(8), .RESET_PC(16'h0000)
    ) dut (
        .clk(clk), .r(r), .a(a), .off(off), .we(we), .call(call), .ret(ret),
        .br(br), .e(e), .oe(oe), .o(o), .pc_q(pc_q), .depth(depth),
        .full(full), .empty(empty), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic idle();
        r = 0; we = 0; call = 0; ret = 0; br = 0; e = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic load(input logic [15:0] v);
        we = 1; a = v; step();
    endtask

    logic [31:0] zz;
    logic [15:0] tgt;

    initial begin
        zz = {16'h0000, {16{1'bz}}};
        idle(); a = '0; off = '0; oe = 1;
        #2;

        // Reset state
        r = 1; step();
        check("rst_pc", pc_q, 16'h0000);
        check("rst_o", o, 16'h0000);
        check("rst_depth", depth, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ovf", ovf, 0);
        check("rst_unf", unf, 0);

        // Increment and wrap
        for (int i = 1; i <= 3; i++) begin
            e = 1; step();
            check("inc_pc", pc_q, i);
            check("inc_o", o, i);
        end
        load(16'hFFFF);
        check("load_pc", pc_q, 16'hFFFF);
        e = 1; step();
        check("inc_wrap", pc_q, 16'h0000);

        // Relative branches
        load(16'h0010); br = 1; off = 8'hF0; step();
        check("br_neg", pc_q, 16'h0000);
        load(16'h0010); br = 1; off = 8'h7F; step();
        check("br_pos", pc_q, 16'h008F);
        load(16'h0005); br = 1; off = 8'hF0; step();
        check("br_wrap", pc_q, 16'hFFF5);

        // Call / return
        load(16'h0100); call = 1; a = 16'h2000; step();
        check("call_pc", pc_q, 16'h2000);
        check("call_depth", depth, 1);
        check("call_empty", empty, 0);
        ret = 1; step();
        check("ret_pc", pc_q, 16'h0101);
        check("ret_depth", depth, 0);
        check("ret_empty", empty, 1);

        // Return while empty
        ret = 1; step();
        check("unf_depth", depth, 0);
`ifdef PROGRAM_SEQUENCER_STACK_GUARD_EN
        check("unf_pc", pc_q, 16'h0101);
        check("unf_flag", unf, 1);
        e = 1; step();
        check("unf_sticky", unf, 1);
`else
        check("unf_flag", unf, 0);
`endif
        r = 1; step();
        check("unf_clr", unf, 0);

        // Nested calls to full
        for (int i = 0; i < 8; i++) begin
            call = 1; a = 16'h1000 + 16'(i * 16'h10); step();
            check("nest_depth", depth, i + 1);
            check("nest_full", full, (i == 7) ? 1 : 0);
        end
        call = 1; a = 16'h5000; step();
        check("ninth_depth", depth, 8);
        check("ninth_full", full, 1);
`ifdef PROGRAM_SEQUENCER_STACK_GUARD_EN
        check("ninth_pc", pc_q, 16'h1070);
        check("ninth_ovf", ovf, 1);
        tgt = 16'h1061;
`else
        check("ninth_pc", pc_q, 16'h5000);
        check("ninth_ovf", ovf, 0);
        tgt = 16'h1071;
`endif
        ret = 1; step();
        check("pop1_pc", pc_q, tgt);
        for (int i = 1; i < 8; i++) begin
            ret = 1; step();
        end
        check("pop8_depth", depth, 0);
        check("pop8_empty", empty, 1);
`ifdef PROGRAM_SEQUENCER_STACK_GUARD_EN
        check("pop8_pc", pc_q, 16'h0001);
        check("ovf_sticky", ovf, 1);
`else
        check("pop8_pc", pc_q, 16'h1001);
`endif
        r = 1; step();
        check("ovf_clr", ovf, 0);

        // Priority
        we = 1; a = 16'h1234; call = 1; e = 1; step();
        check("prio_we_pc", pc_q, 16'h1234);
        check("prio_we_depth", depth, 0);
        call = 1; a = 16'h0040; step();
        check("prio_push", depth, 1);
        r = 1; we = 1; call = 1; ret = 1; br = 1; e = 1; a = 16'h7777; step();
        check("prio_r_pc", pc_q, 16'h0000);
        check("prio_r_depth", depth, 0);

        // Tri-state output
        oe = 0; e = 1; step();
        check("oe0_o", {16'h0000, o}, zz);
        check("oe0_pc", pc_q, 16'h0001);
        e = 1; step();
        check("oe0_pc2", pc_q, 16'h0002);
        oe = 1; #1;
        check("oe1_o", o, 16'h0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
